// File: rtl/edac_err_log_if.sv
// EDAC flag / error-log bus between the ECC aggregate, the host, and the error logger.
// The master is the ECC/host side. The slave is the logger.
interface edac_err_log_if #(
  parameter int RAM_LOGDEPTH  = 8,
  parameter int FIFO_LOGDEPTH = 3,
  parameter int CNT_WIDTH     = 16
);
  logic                     clr;
  logic                     correctable;
  logic                     error;
  logic [RAM_LOGDEPTH-1:0]  ram_rA_lat;
  logic                     scrub_corr;
  logic                     log_rd;
  logic                     log_vld;
  logic [RAM_LOGDEPTH-1:0]  log_addr;
  logic                     log_type;
  logic [FIFO_LOGDEPTH:0]   fifo_level;
  logic                     log_ovf;
  logic [CNT_WIDTH-1:0]     corr_cnt;
  logic [CNT_WIDTH-1:0]     uncorr_cnt;
  logic [CNT_WIDTH-1:0]     scrub_cnt;
  logic                     irq;

  modport master (
    output clr, correctable, error, ram_rA_lat, scrub_corr, log_rd,
    input  log_vld, log_addr, log_type, fifo_level, log_ovf,
           corr_cnt, uncorr_cnt, scrub_cnt, irq
  );

  modport slave (
    input  clr, correctable, error, ram_rA_lat, scrub_corr, log_rd,
    output log_vld, log_addr, log_type, fifo_level, log_ovf,
           corr_cnt, uncorr_cnt, scrub_cnt, irq
  );
endinterface

// File: rtl/edac_err_log.sv
// EDAC error logger: saturating event counters, a show-ahead address/type log FIFO
// with sticky overflow, and a registered level interrupt.
module edac_err_log #(
  parameter int RAM_LOGDEPTH  = 8,
  parameter int FIFO_LOGDEPTH = 3,
  parameter int CNT_WIDTH     = 16,
  parameter int IRQ_THRESH    = 1
) (
  input  logic            clk,
  input  logic            nGrst,
  edac_err_log_if.slave   bus
);
  localparam int LW = FIFO_LOGDEPTH + 1;
  localparam logic [LW-1:0]            FULL_LVL = {1'b1, {FIFO_LOGDEPTH{1'b0}}};
  localparam logic [LW-1:0]            THR      = LW'(IRQ_THRESH);
  localparam logic [LW-1:0]            LVL_ONE  = LW'(1);
  localparam logic [FIFO_LOGDEPTH-1:0] PTR_ONE  = FIFO_LOGDEPTH'(1);
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE  = CNT_WIDTH'(1);

  typedef struct packed {
    logic [RAM_LOGDEPTH-1:0] addr;
    logic                    typ;
  } entry_t;

  entry_t                    mem [1<<FIFO_LOGDEPTH];
  logic [FIFO_LOGDEPTH-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]             level, level_nxt;
  logic                      ovf, ovf_nxt, irq_q;
  logic [CNT_WIDTH-1:0]      corr_q, unc_q, scr_q;

  logic ev_unc, ev_cor, push_req, pop, full, push;

  always_comb begin
    ev_unc    = bus.error;
    ev_cor    = bus.correctable & ~bus.error;
    push_req  = ev_unc | ev_cor;
    pop       = bus.log_rd & (level != '0);
    full      = (level == FULL_LVL);
    // A full FIFO can still take a push if the head leaves in the same cycle
    push      = push_req & (~full | pop);
    ovf_nxt   = ovf | (push_req & full & ~pop);
    level_nxt = level;
    if (push & ~pop)      level_nxt = level + LVL_ONE;
    else if (pop & ~push) level_nxt = level - LVL_ONE;
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(logic [CNT_WIDTH-1:0] c, logic ev);
    return (ev && c != '1) ? c + CNT_ONE : c;
  endfunction

  always_ff @(posedge clk) begin
    if (!nGrst || bus.clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      irq_q  <= 1'b0;
      corr_q <= '0;
      unc_q  <= '0;
      scr_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      level  <= level_nxt;
      ovf    <= ovf_nxt;
      irq_q  <= (level_nxt >= THR) | ovf_nxt;
      corr_q <= sat_inc(corr_q, ev_cor);
      unc_q  <= sat_inc(unc_q, ev_unc);
      scr_q  <= sat_inc(scr_q, bus.scrub_corr);
    end
  end

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (nGrst && !bus.clr && push) mem[wr_ptr] <= '{addr: bus.ram_rA_lat, typ: ev_unc};
  end

  // Head is gated so the outputs read 0 (never X) while the FIFO is empty.
  assign bus.log_vld    = (level != '0);
  assign bus.log_addr   = bus.log_vld ? mem[rd_ptr].addr : '0;
  assign bus.log_type   = bus.log_vld ? mem[rd_ptr].typ  : 1'b0;
  assign bus.fifo_level = level;
  assign bus.log_ovf    = ovf;
  assign bus.corr_cnt   = corr_q;
  assign bus.uncorr_cnt = unc_q;
  assign bus.scrub_cnt  = scr_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_edac_err_log.sv
// Directed bench for edac_err_log: vector table plus FIFO full/overflow, saturation
// and mid-burst reset sequences.
module tb_edac_err_log;
  localparam int RAM_LOGDEPTH  = 8;
  localparam int FIFO_LOGDEPTH = 3;
  localparam int CNT_WIDTH     = 4;
  localparam int IRQ_THRESH    = 1;

  logic clk = 1'b0;
  logic nGrst;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  edac_err_log_if #(.RAM_LOGDEPTH(RAM_LOGDEPTH), .FIFO_LOGDEPTH(FIFO_LOGDEPTH),
                    .CNT_WIDTH(CNT_WIDTH)) bus ();

  edac_err_log #(.RAM_LOGDEPTH(RAM_LOGDEPTH), .FIFO_LOGDEPTH(FIFO_LOGDEPTH),
                 .CNT_WIDTH(CNT_WIDTH), .IRQ_THRESH(IRQ_THRESH)) dut (
    .clk(clk), .nGrst(nGrst), .bus(bus)
  );

  typedef struct {
    logic       corr, err, scrub, rd, clr;
    logic [7:0] addr;
    logic       e_vld;
    logic [7:0] e_addr;
    logic       e_type;
    logic [3:0] e_lvl;
    logic       e_ovf;
    logic [3:0] e_c, e_u, e_s;
    logic       e_irq;
    string      name;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.correctable = 0; bus.error = 0; bus.scrub_corr = 0;
    bus.log_rd = 0; bus.clr = 0; bus.ram_rA_lat = '0;
  endtask

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
    else passed++;
  endtask

  task automatic chk_all(string n, logic vld, logic [7:0] addr, logic typ, logic [3:0] lvl,
                         logic ovf, logic [3:0] c, logic [3:0] u, logic [3:0] s, logic irq);
    chk({n, ".log_vld"},    32'(bus.log_vld),    32'(vld));
    chk({n, ".log_addr"},   32'(bus.log_addr),   32'(addr));
    chk({n, ".log_type"},   32'(bus.log_type),   32'(typ));
    chk({n, ".fifo_level"}, 32'(bus.fifo_level), 32'(lvl));
    chk({n, ".log_ovf"},    32'(bus.log_ovf),    32'(ovf));
    chk({n, ".corr_cnt"},   32'(bus.corr_cnt),   32'(c));
    chk({n, ".uncorr_cnt"}, 32'(bus.uncorr_cnt), 32'(u));
    chk({n, ".scrub_cnt"},  32'(bus.scrub_cnt),  32'(s));
    chk({n, ".irq"},        32'(bus.irq),        32'(irq));
  endtask

  task automatic do_clr();
    idle(); bus.clr = 1; step(); bus.clr = 0;
  endtask

  initial begin
    //            corr err scr rd clr addr   vld addr  typ lvl ovf c u s irq
    vecs[0] = '{0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, "rd_empty"};
    vecs[1] = '{1, 0, 0, 0, 0, 8'h3A, 1, 8'h3A, 0, 1, 0, 1, 0, 0, 1, "cor_3a"};
    vecs[2] = '{0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, "pop_3a"};
    vecs[3] = '{1, 1, 1, 0, 0, 8'h05, 1, 8'h05, 1, 1, 0, 1, 1, 1, 1, "unc_both_scrub"};
    vecs[4] = '{1, 0, 0, 1, 0, 8'h11, 1, 8'h11, 0, 1, 0, 2, 1, 1, 1, "push_pop"};
    vecs[5] = '{0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 2, 1, 1, 0, "pop_11"};
    vecs[6] = '{0, 1, 0, 1, 0, 8'h22, 1, 8'h22, 1, 1, 0, 2, 2, 1, 1, "empty_push_rd"};
    vecs[7] = '{0, 1, 0, 0, 1, 8'h33, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, "clr_with_err"};
    vecs[8] = '{0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, "idle_after_clr"};

    idle();
    nGrst = 0;
    step(); step();
    nGrst = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("reset_idle", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    end

    for (int i = 0; i < 9; i++) begin
      bus.correctable = vecs[i].corr; bus.error = vecs[i].err;
      bus.scrub_corr = vecs[i].scrub; bus.log_rd = vecs[i].rd;
      bus.clr = vecs[i].clr; bus.ram_rA_lat = vecs[i].addr;
      step();
      chk_all(vecs[i].name, vecs[i].e_vld, vecs[i].e_addr, vecs[i].e_type, vecs[i].e_lvl,
              vecs[i].e_ovf, vecs[i].e_c, vecs[i].e_u, vecs[i].e_s, vecs[i].e_irq);
    end
    idle();

    // 10 back-to-back correctable events into an 8-deep FIFO
    for (int i = 0; i < 10; i++) begin
      bus.correctable = 1; bus.ram_rA_lat = 8'(i);
      step();
    end
    idle();
    chk_all("fill10", 1, 8'h00, 0, 8, 1, 10, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("pop_order.addr", 32'(bus.log_addr), 32'(i));
      bus.log_rd = 1; step(); bus.log_rd = 0;
    end
    chk_all("drained_ovf", 0, 8'h00, 0, 0, 1, 10, 0, 0, 1);
    do_clr();
    chk_all("clr_after_ovf", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

    // Full FIFO with push and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      bus.correctable = 1; bus.ram_rA_lat = 8'(i);
      step();
    end
    chk("full8.level", 32'(bus.fifo_level), 32'd8);
    bus.correctable = 1; bus.ram_rA_lat = 8'h08; bus.log_rd = 1;
    step();
    idle();
    chk_all("full_push_pop", 1, 8'h01, 0, 8, 0, 9, 0, 0, 1);
    do_clr();

    // Scrub counter saturation at 15
    for (int i = 0; i < 20; i++) begin
      bus.scrub_corr = 1;
      step();
      if (i == 13) chk("scrub_14", 32'(bus.scrub_cnt), 32'd14);
      if (i == 14) chk("scrub_15", 32'(bus.scrub_cnt), 32'd15);
    end
    idle();
    chk_all("scrub_sat", 0, 8'h00, 0, 0, 0, 0, 0, 15, 0);
    bus.error = 1; bus.ram_rA_lat = 8'h77; bus.clr = 1;
    step();
    idle();
    chk_all("clr_err_sat", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of an event burst
    for (int i = 0; i < 5; i++) begin
      bus.correctable = 1; bus.ram_rA_lat = 8'(8'h40 + i);
      step();
    end
    chk_all("fill5", 1, 8'h40, 0, 5, 0, 5, 0, 0, 1);
    bus.correctable = 1; bus.ram_rA_lat = 8'h45; nGrst = 0;
    step();
    chk_all("reset_mid_burst", 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    nGrst = 1; bus.correctable = 1; bus.ram_rA_lat = 8'h50;
    step();
    idle();
    chk_all("post_reset_push", 1, 8'h50, 0, 1, 0, 1, 0, 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
